// File: rtl/bucket_dump.sv
// Post-epoch reader for a part_1 bucket RAM: scans every address, streams the
// non-empty {ID, count} entries through a small credit-managed FIFO, and can clear buckets as it goes.
module bucket_dump #(
    parameter int unsigned RAM_PTR    = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear_en,
    output logic               busy,
    output logic               done,
    output logic [RAM_PTR:0]   entry_cnt,
    output logic               ram_rd_en,
    output logic [RAM_PTR-1:0] ram_rd_addr,
    input  logic [63:0]        ram_rd_data,
    output logic               ram_wr_en,
    output logic [RAM_PTR-1:0] ram_wr_addr,
    output logic [63:0]        ram_wr_data,
    output logic [63:0]        e_f_out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ECNT_W = RAM_PTR + 1;
    localparam logic [RAM_PTR-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [RAM_PTR-1:0]   rd_ptr, rd_ptr_nxt;
    logic                 clr_lat, clr_nxt;
    logic                 rd_vld_d;
    logic [RAM_PTR-1:0]   rd_addr_d;

    logic [DATA_W-1:0]    mem [FIFO_DEPTH];
    logic [IDX_W-1:0]     rd_idx, rd_idx_nxt;
    logic [IDX_W-1:0]     wr_idx, wr_idx_nxt;
    logic [CNT_W-1:0]     cnt, cnt_pop, cnt_nxt;
    logic [CNT_W:0]       credit_use;
    logic                 credit_ok;
    logic                 push, pop;

    logic                 busy_nxt, done_nxt;
    logic [ECNT_W-1:0]    ecnt_nxt;
    logic                 rd_en_nxt;
    logic [RAM_PTR-1:0]   rd_addr_nxt;
    logic                 wr_en_nxt;
    logic [RAM_PTR-1:0]   wr_addr_nxt;
    logic [DATA_W-1:0]    head_nxt;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(FIFO_DEPTH - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Next-state, FIFO bookkeeping and next values of every registered output
    always_comb begin
        state_nxt   = state;
        rd_ptr_nxt  = rd_ptr;
        clr_nxt     = clr_lat;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        ecnt_nxt    = entry_cnt;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = ram_rd_addr;

        pop        = out_valid && out_ready;
        push       = rd_vld_d && (ram_rd_data != '0);
        cnt_pop    = cnt - CNT_W'(pop);
        cnt_nxt    = cnt_pop + CNT_W'(push);
        rd_idx_nxt = pop  ? idx_inc(rd_idx) : rd_idx;
        wr_idx_nxt = push ? idx_inc(wr_idx) : wr_idx;

        // Head register: bypass the returning word when the FIFO would otherwise be empty
        if (cnt_nxt == '0) begin
            head_nxt = '0;
        end else if (cnt_pop == '0) begin
            head_nxt = ram_rd_data;
        end else begin
            head_nxt = mem[rd_idx_nxt];
        end

        // The read issued now lands two edges later; count it against the FIFO space
        credit_use = {1'b0, cnt_nxt} + (CNT_W + 1)'(ram_rd_en);
        credit_ok  = credit_use <= (CNT_W + 1)'(FIFO_DEPTH - 2);

        if (pop) begin
            ecnt_nxt = entry_cnt + ECNT_W'(1);
        end

        wr_en_nxt   = rd_vld_d && clr_lat;
        wr_addr_nxt = rd_vld_d ? rd_addr_d : ram_wr_addr;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_SCAN;
                    clr_nxt     = clear_en;
                    busy_nxt    = 1'b1;
                    ecnt_nxt    = '0;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                    rd_ptr_nxt  = RAM_PTR'(1);
                end
            end
            S_SCAN: begin
                if (credit_ok) begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = rd_ptr;
                    rd_ptr_nxt  = rd_ptr + RAM_PTR'(1);
                    if (rd_ptr == LAST_ADDR) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((cnt_nxt == '0) && !ram_rd_en && !rd_vld_d) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rd_ptr      <= '0;
            clr_lat     <= 1'b0;
            rd_vld_d    <= 1'b0;
            rd_addr_d   <= '0;
            cnt         <= '0;
            rd_idx      <= '0;
            wr_idx      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            entry_cnt   <= '0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            e_f_out     <= '0;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_ptr      <= rd_ptr_nxt;
            clr_lat     <= clr_nxt;
            rd_vld_d    <= ram_rd_en;
            rd_addr_d   <= ram_rd_addr;
            cnt         <= cnt_nxt;
            rd_idx      <= rd_idx_nxt;
            wr_idx      <= wr_idx_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            entry_cnt   <= ecnt_nxt;
            ram_rd_en   <= rd_en_nxt;
            ram_rd_addr <= rd_addr_nxt;
            ram_wr_en   <= wr_en_nxt;
            ram_wr_addr <= wr_addr_nxt;
            e_f_out     <= head_nxt;
            out_valid   <= (cnt_nxt != '0);
        end
    end

    // FIFO storage carries no reset; occupancy and pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= ram_rd_data;
        end
    end

    assign ram_wr_data = '0;

endmodule

// File: doc/bucket_dump.md
# bucket_dump

Read-side companion to the part_1 insertion stage: after a measurement epoch, scans one part_1 bucket RAM from address 0 to 2^RAM_PTR−1 and streams every non-empty 64-bit {ID[63:32], count[31:0]} entry out over a valid/ready interface. Optional clear-on-read zeroes each scanned bucket so the sketch is empty for the next epoch. Sits between the bucket RAM's spare read/write ports and the host/report path; part_1 insertion is halted by system control while `busy` is high.

## Interface
Parameters
- RAM_PTR, 10, bucket RAM address width; scan covers 2^RAM_PTR entries
- FIFO_DEPTH, 4, output buffer depth (fixed minimum 4)

Ports
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a scan when idle
- clear_en  input  1  sampled with start; 1 = zero each bucket after reading
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse at scan completion
- entry_cnt  output  RAM_PTR+1  number of entries emitted in last/current scan
- ram_rd_en  output  1  RAM read enable
- ram_rd_addr  output  RAM_PTR  RAM read address
- ram_rd_data  input  64  RAM read data, valid exactly 1 cycle after ram_rd_en
- ram_wr_en  output  1  RAM write enable (clear path)
- ram_wr_addr  output  RAM_PTR  RAM write address
- ram_wr_data  output  64  RAM write data, always 64'b0
- e_f_out  output  64  emitted {ID, count}
- out_valid  output  1  e_f_out valid
- out_ready  input  1  downstream accepts when high with out_valid

## Operation
- All outputs registered; reset value of every output 0 (busy, done, entry_cnt, ram_*, e_f_out, out_valid). Reset mid-scan aborts: FIFO emptied, address/credit counters zeroed, state IDLE, no done pulse.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: start=1 → latch clear_en, rd_ptr=0, entry_cnt=0, → SCAN. start ignored in all other states.
  - SCAN: issue one read per cycle while credit allows; rd_ptr increments after each issue; after issuing address 2^RAM_PTR−1 → DRAIN (no wrap, no further reads).
  - DRAIN: wait for in-flight read = 0 and FIFO empty → DONE.
  - DONE: done=1 for one cycle, busy drops same edge, → IDLE.
- Credit rule: a read is issued only if FIFO occupancy + reads in flight ≤ FIFO_DEPTH−2; FIFO never overflows and no entry is lost under any out_ready pattern.
- Returned data == 64'b0: not pushed (empty bucket skipped). Non-zero: pushed to FIFO; entry_cnt increments on each out_valid&&out_ready handshake.
- Clear: if latched clear_en=1, every scanned address (empty or not) gets ram_wr_en=1, ram_wr_data=0 one cycle after its data returns. clear_en=0 → ram_wr_en never asserted.
- Output handshake: e_f_out/out_valid hold stable while out_valid=1 and out_ready=0; FIFO order = address order.
- entry_cnt holds after done until next accepted start; max value 2^RAM_PTR fits RAM_PTR+1 bits.

## Timing
- start sampled at edge E0; busy=1 and first ram_rd_en=1 (addr 0) in cycle after E0.
- Read issued in cycle t → ram_rd_data sampled end of t+1 → out_valid earliest in t+2; clear write for that address in t+2.
- out_ready held high: sustained 1 read/cycle and 1 output/cycle; full scan of N=2^RAM_PTR all-non-empty entries completes with done in cycle N+3 after start edge.
- out_ready low: reads stall within 2 cycles; resume within 1 cycle of out_ready rising.
- Simultaneous FIFO push and pop in same cycle: occupancy unchanged, both take effect.

## Test plan
- RAM_PTR=4, RAM preloaded addr k = {k+1, 10·k} for all 16, out_ready=1, clear_en=0 → 16 outputs in address order, first {1,0}, last {16,150}; entry_cnt=16; done 1 cycle; ram_wr_en never 1; RAM unchanged.
- Only addr 3 = {0xA,5} and addr 15 = {0xB,7}, rest 0 → exactly 2 outputs in that order; entry_cnt=2.
- Full RAM, clear_en=1 → all 16 emitted, 16 zero-writes one per address; second scan emits 0 entries, entry_cnt=0.
- Full RAM, out_ready toggled randomly (incl. 20-cycle low stretch) → 16 outputs, no loss/duplication, e_f_out stable while stalled, FIFO occupancy ≤ 4.
- start pulsed again mid-scan → ignored, single done, entry_cnt=16.
- rst_n asserted at cycle 8 of scan → all outputs 0 immediately; new start afterwards gives complete correct 16-entry scan.
